// File: rtl/mbus_axi_rd_if.sv
// Handshake bundle between the frame-read requester, the AXI4 read port and the read master.
// Define RD_LAST_CHECK_EN to add the o_last_err output.
interface mbus_axi_rd_if #(
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int BURST_LENGTH    = 8,
  parameter int CTRL_ADDR_WIDTH = 28
);
  localparam int DW = MEM_DQ_WIDTH * BURST_LENGTH;

  logic                       i_mbus_rrq;
  logic [CTRL_ADDR_WIDTH-1:0] i_mbus_raddr;
  logic                       i_mbus_rready;
  logic [DW-1:0]              o_mbus_rdata;
  logic                       o_mbus_rdata_rq;
  logic                       o_mbus_rbusy;
  logic                       o_mbus_rsel;
  logic [CTRL_ADDR_WIDTH-1:0] o_axi_araddr;
  logic [7:0]                 o_axi_arlen;
  logic                       o_axi_arvalid;
  logic                       i_axi_arready;
  logic [DW-1:0]              i_axi_rdata;
  logic [1:0]                 i_axi_rresp;
  logic                       i_axi_rlast;
  logic                       i_axi_rvalid;
  logic                       o_axi_rready;
  logic [7:0]                 o_rd_err_cnt;
`ifdef RD_LAST_CHECK_EN
  logic                       o_last_err;

  modport master (
    input  i_mbus_rrq, i_mbus_raddr, i_mbus_rready,
    input  i_axi_arready, i_axi_rdata, i_axi_rresp, i_axi_rlast, i_axi_rvalid,
    output o_mbus_rdata, o_mbus_rdata_rq, o_mbus_rbusy, o_mbus_rsel,
    output o_axi_araddr, o_axi_arlen, o_axi_arvalid, o_axi_rready, o_rd_err_cnt,
    output o_last_err
  );
  modport slave (
    output i_mbus_rrq, i_mbus_raddr, i_mbus_rready,
    output i_axi_arready, i_axi_rdata, i_axi_rresp, i_axi_rlast, i_axi_rvalid,
    input  o_mbus_rdata, o_mbus_rdata_rq, o_mbus_rbusy, o_mbus_rsel,
    input  o_axi_araddr, o_axi_arlen, o_axi_arvalid, o_axi_rready, o_rd_err_cnt,
    input  o_last_err
  );
`else
  modport master (
    input  i_mbus_rrq, i_mbus_raddr, i_mbus_rready,
    input  i_axi_arready, i_axi_rdata, i_axi_rresp, i_axi_rlast, i_axi_rvalid,
    output o_mbus_rdata, o_mbus_rdata_rq, o_mbus_rbusy, o_mbus_rsel,
    output o_axi_araddr, o_axi_arlen, o_axi_arvalid, o_axi_rready, o_rd_err_cnt
  );
  modport slave (
    output i_mbus_rrq, i_mbus_raddr, i_mbus_rready,
    output i_axi_arready, i_axi_rdata, i_axi_rresp, i_axi_rlast, i_axi_rvalid,
    input  o_mbus_rdata, o_mbus_rdata_rq, o_mbus_rbusy, o_mbus_rsel,
    input  o_axi_araddr, o_axi_arlen, o_axi_arvalid, o_axi_rready, o_rd_err_cnt
  );
`endif
endinterface

// File: rtl/mbus_axi_rd_master.sv
// Single-client mbus-to-AXI4 read master: one INCR burst of BURST_BEATS beats per grant, beats out 1 cycle after R handshake.
// Define RD_LAST_CHECK_EN to end bursts on the beat count and flag rlast misplacement on o_last_err.
module mbus_axi_rd_master #(
  parameter int MEM_DQ_WIDTH    = 16,
  parameter int BURST_LENGTH    = 8,
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int BURST_BEATS     = 16
) (
  input logic            i_axi_aclk,
  input logic            i_rst,
  mbus_axi_rd_if.master  bus
);
  localparam int DW = MEM_DQ_WIDTH * BURST_LENGTH;
  localparam int CW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                     r_state;
  logic [CTRL_ADDR_WIDTH-1:0] r_araddr;
  logic                       r_arvalid;
  logic                       r_rready;
  logic                       r_rsel;
  logic                       r_rbusy;
  logic [DW-1:0]              r_rdata;
  logic                       r_rdata_rq;
  logic [7:0]                 r_err_cnt;
  logic [CW-1:0]              r_cnt;

  logic w_beat;
  logic w_end;

  assign w_beat = (r_state == S_DATA) && bus.i_axi_rvalid;

`ifdef RD_LAST_CHECK_EN
  logic r_last_err;
  logic r_last_bad;

  // Beat count alone closes the burst; rlast is only audited.
  assign w_end = w_beat && (r_cnt == LAST_BEAT);
  assign bus.o_last_err = r_last_err;
`else
  assign w_end = w_beat && bus.i_axi_rlast;
`endif

  always_ff @(posedge i_axi_aclk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_araddr   <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rsel     <= 1'b0;
      r_rbusy    <= 1'b0;
      r_rdata    <= '0;
      r_rdata_rq <= 1'b0;
      r_err_cnt  <= '0;
      r_cnt      <= '0;
`ifdef RD_LAST_CHECK_EN
      r_last_err <= 1'b0;
      r_last_bad <= 1'b0;
`endif
    end else begin
      r_rdata_rq <= 1'b0;
`ifdef RD_LAST_CHECK_EN
      r_last_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.i_mbus_rrq && bus.i_mbus_rready) begin
            r_araddr  <= bus.i_mbus_raddr;
            r_arvalid <= 1'b1;
            r_rsel    <= 1'b1;
            r_rbusy   <= 1'b1;
            r_cnt     <= '0;
`ifdef RD_LAST_CHECK_EN
            r_last_bad <= 1'b0;
`endif
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.i_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_rdata    <= bus.i_axi_rdata;
            r_rdata_rq <= 1'b1;
            r_cnt      <= (w_end || r_cnt == LAST_BEAT) ? '0 : r_cnt + 1'b1;
            if (bus.i_axi_rresp != 2'b00 && r_err_cnt != 8'hFF)
              r_err_cnt <= r_err_cnt + 8'd1;
`ifdef RD_LAST_CHECK_EN
            if (bus.i_axi_rlast && r_cnt != LAST_BEAT)
              r_last_bad <= 1'b1;
`endif
          end
          if (w_end) begin
            r_rready <= 1'b0;
            r_rsel   <= 1'b0;
            r_rbusy  <= 1'b0;
`ifdef RD_LAST_CHECK_EN
            r_last_err <= r_last_bad || !bus.i_axi_rlast;
`endif
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_mbus_rdata    = r_rdata;
  assign bus.o_mbus_rdata_rq = r_rdata_rq;
  assign bus.o_mbus_rbusy    = r_rbusy;
  assign bus.o_mbus_rsel     = r_rsel;
  assign bus.o_axi_araddr    = r_araddr;
  assign bus.o_axi_arlen     = 8'(BURST_BEATS - 1);
  assign bus.o_axi_arvalid   = r_arvalid;
  assign bus.o_axi_rready    = r_rready;
  assign bus.o_rd_err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_mbus_axi_rd_master.sv
// Directed bench for mbus_axi_rd_master: grant, AR stall, beat forwarding, error count, reset, rlast handling.
module tb_mbus_axi_rd_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mbus_axi_rd_if #(.MEM_DQ_WIDTH(16), .BURST_LENGTH(8), .CTRL_ADDR_WIDTH(28)) bus ();

  mbus_axi_rd_master #(
    .MEM_DQ_WIDTH(16), .BURST_LENGTH(8), .CTRL_ADDR_WIDTH(28), .BURST_BEATS(16)
  ) u_dut (
    .i_axi_aclk (clk),
    .i_rst      (rst),
    .bus        (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  always @(negedge clk) if (bus.o_mbus_rdata_rq) pulse_cnt <= pulse_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] beat_dat(input int id, input int i);
    return (128'(id) << 64) | 128'(i);
  endfunction

  task automatic burst(input logic [27:0] addr, input int ar_stall, input bit gaps,
                       input int rlast_at, input int nbeats, input logic [15:0] err_mask,
                       input int id, input bit exp_last_err, input bit hold_rrq,
                       input logic [27:0] next_addr);
    int base;
    base = pulse_cnt;
    bus.i_mbus_raddr  = addr;
    bus.i_mbus_rrq    = 1'b1;
    bus.i_mbus_rready = 1'b1;
    bus.i_axi_arready = (ar_stall == 0);
    tick;
    bus.i_mbus_rrq   = 1'b0;
    bus.i_mbus_raddr = ~addr;
    chk("grant_arvalid", bus.o_axi_arvalid, 1'b1);
    chk("grant_araddr", bus.o_axi_araddr, addr);
    chk("grant_rsel", bus.o_mbus_rsel, 1'b1);
    chk("grant_rbusy", bus.o_mbus_rbusy, 1'b1);
    for (int s = 0; s < ar_stall; s++) begin
      tick;
      chk("ar_stall_arvalid", bus.o_axi_arvalid, 1'b1);
      chk("ar_stall_araddr", bus.o_axi_araddr, addr);
    end
    bus.i_axi_arready = 1'b1;
    tick;
    bus.i_axi_arready = 1'b0;
    chk("ar_done_arvalid", bus.o_axi_arvalid, 1'b0);
    chk("data_rready", bus.o_axi_rready, 1'b1);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        tick;
        chk("gap_no_rq", bus.o_mbus_rdata_rq, 1'b0);
      end
      bus.i_axi_rvalid = 1'b1;
      bus.i_axi_rdata  = beat_dat(id, i);
      bus.i_axi_rresp  = err_mask[i] ? 2'd2 : 2'd0;
      bus.i_axi_rlast  = (i + 1 == rlast_at);
      tick;
      bus.i_axi_rvalid = 1'b0;
      bus.i_axi_rlast  = 1'b0;
      bus.i_axi_rresp  = 2'd0;
      chk("beat_rq", bus.o_mbus_rdata_rq, 1'b1);
      chk("beat_dat", bus.o_mbus_rdata, beat_dat(id, i));
      if (i < nbeats - 1) begin
        chk("mid_rbusy", bus.o_mbus_rbusy, 1'b1);
        chk("mid_rsel", bus.o_mbus_rsel, 1'b1);
      end
    end
    if (hold_rrq) begin
      bus.i_mbus_rrq   = 1'b1;
      bus.i_mbus_raddr = next_addr;
    end
    chk("done_rbusy", bus.o_mbus_rbusy, 1'b0);
    chk("done_rsel", bus.o_mbus_rsel, 1'b0);
    chk("done_rready", bus.o_axi_rready, 1'b0);
`ifdef RD_LAST_CHECK_EN
    chk("done_last_err", bus.o_last_err, exp_last_err);
`endif
    @(negedge clk);
    #1;
    chk("pulse_count", 128'(pulse_cnt - base), 128'(nbeats));
  endtask

  initial begin
    rst = 1'b1;
    bus.i_mbus_rrq = 0; bus.i_mbus_raddr = '0; bus.i_mbus_rready = 0;
    bus.i_axi_arready = 0; bus.i_axi_rdata = '0; bus.i_axi_rresp = 0;
    bus.i_axi_rlast = 0; bus.i_axi_rvalid = 0;
    tick;
    tick;
    chk("rst_arvalid", bus.o_axi_arvalid, 1'b0);
    chk("rst_rsel", bus.o_mbus_rsel, 1'b0);
    chk("rst_rbusy", bus.o_mbus_rbusy, 1'b0);
    chk("rst_rdata_rq", bus.o_mbus_rdata_rq, 1'b0);
    chk("rst_rready", bus.o_axi_rready, 1'b0);
    chk("rst_err_cnt", bus.o_rd_err_cnt, 8'd0);
    chk("rst_araddr", bus.o_axi_araddr, 28'd0);
    chk("arlen", bus.o_axi_arlen, 8'd15);
    rst = 1'b0;
    tick;

    // Single burst, AR accepted immediately.
    burst(28'h00FD200, 0, 1'b0, 16, 16, 16'h0000, 0, 1'b0, 1'b0, 28'h0);
    tick;
    chk("idle_no_rq", bus.o_mbus_rdata_rq, 1'b0);

    // Requester not ready: no grant for 10 cycles.
    bus.i_mbus_rrq = 1'b1; bus.i_mbus_rready = 1'b0; bus.i_mbus_raddr = 28'h0001234;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("bp_arvalid", bus.o_axi_arvalid, 1'b0);
      chk("bp_rsel", bus.o_mbus_rsel, 1'b0);
    end
    burst(28'h0001234, 0, 1'b0, 16, 16, 16'h0000, 1, 1'b0, 1'b0, 28'h0);
    tick;

    // AR stall plus rvalid gaps.
    burst(28'h0002000, 5, 1'b1, 16, 16, 16'h0000, 2, 1'b0, 1'b0, 28'h0);
    tick;

    // Error beats 3 and 7, then saturation.
    burst(28'h0003000, 0, 1'b0, 16, 16, 16'h0044, 3, 1'b0, 1'b0, 28'h0);
    tick;
    chk("err_cnt_two", bus.o_rd_err_cnt, 8'd2);
    for (int b = 0; b < 15; b++) begin
      burst(28'h0003100, 0, 1'b0, 16, 16, 16'hFFFF, 4, 1'b0, 1'b0, 28'h0);
      tick;
    end
    chk("err_cnt_242", bus.o_rd_err_cnt, 8'd242);
    for (int b = 0; b < 4; b++) begin
      burst(28'h0003200, 0, 1'b0, 16, 16, 16'hFFFF, 5, 1'b0, 1'b0, 28'h0);
      tick;
    end
    chk("err_cnt_sat", bus.o_rd_err_cnt, 8'd255);

    // Request held through DONE: ignored there, granted on the following IDLE edge.
    burst(28'h0004000, 0, 1'b0, 16, 16, 16'h0000, 6, 1'b0, 1'b1, 28'h0005000);
    tick;
    chk("done_ignores_rrq", bus.o_axi_arvalid, 1'b0);
    burst(28'h0005000, 0, 1'b0, 16, 16, 16'h0000, 7, 1'b0, 1'b0, 28'h0);
    tick;

    // Reset at beat 8 of a burst.
    bus.i_mbus_rrq = 1'b1; bus.i_mbus_rready = 1'b1; bus.i_mbus_raddr = 28'h0006000;
    bus.i_axi_arready = 1'b1;
    tick;
    bus.i_mbus_rrq = 1'b0;
    tick;
    bus.i_axi_arready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.i_axi_rvalid = 1'b1; bus.i_axi_rdata = beat_dat(8, i);
      tick;
    end
    rst = 1'b1; bus.i_axi_rdata = beat_dat(8, 7);
    tick;
    rst = 1'b0; bus.i_axi_rvalid = 1'b0;
    chk("mid_rst_arvalid", bus.o_axi_arvalid, 1'b0);
    chk("mid_rst_rsel", bus.o_mbus_rsel, 1'b0);
    chk("mid_rst_rbusy", bus.o_mbus_rbusy, 1'b0);
    chk("mid_rst_rq", bus.o_mbus_rdata_rq, 1'b0);
    chk("mid_rst_rready", bus.o_axi_rready, 1'b0);
    chk("mid_rst_rdata", bus.o_mbus_rdata, 128'd0);
    chk("mid_rst_araddr", bus.o_axi_araddr, 28'd0);
    chk("mid_rst_err", bus.o_rd_err_cnt, 8'd0);
    bus.i_axi_rvalid = 1'b1; bus.i_axi_rresp = 2'd2;
    tick;
    bus.i_axi_rvalid = 1'b0; bus.i_axi_rresp = 2'd0;
    chk("idle_rvalid_ignored", bus.o_mbus_rdata_rq, 1'b0);
    burst(28'h0000080, 0, 1'b0, 16, 16, 16'h0000, 9, 1'b0, 1'b0, 28'h0);
    tick;
    chk("post_rst_err", bus.o_rd_err_cnt, 8'd0);

    // Early rlast on beat 12.
`ifdef RD_LAST_CHECK_EN
    burst(28'h0007000, 0, 1'b0, 12, 16, 16'h0000, 10, 1'b1, 1'b0, 28'h0);
    tick;
    chk("last_err_one_pulse", bus.o_last_err, 1'b0);
`else
    burst(28'h0007000, 0, 1'b0, 12, 12, 16'h0000, 10, 1'b0, 1'b0, 28'h0);
    tick;
    chk("early_last_idle", bus.o_axi_rready, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mbus_axi_rd_master.md
Name: mbus_axi_rd_master

Overview:
- Read-side bus master between the frame read interface and the DDR controller AXI4 read port.
- Accepts a single-burst read request on the mbus handshake (rrq/raddr/rready) and issues one AXI INCR burst of BURST_BEATS beats.
- Returns each beat as a one-cycle-valid mbus data word; rsel/rbusy frame the whole transaction for the requester.
- Single client, one outstanding burst.

Parameters:
- MEM_DQ_WIDTH, 16: DDR DQ width.
- BURST_LENGTH, 8: DDR burst length. Beat width is MEM_DQ_WIDTH*BURST_LENGTH (128).
- CTRL_ADDR_WIDTH, 28: mbus/AXI address width.
- BURST_BEATS, 16: beats per AXI burst. arlen = BURST_BEATS-1.

Ports:
- i_axi_aclk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_mbus_rrq  in  1  read request, level.
- i_mbus_raddr  in  CTRL_ADDR_WIDTH  burst start address, sampled at grant.
- i_mbus_rready  in  1  requester has room for a full burst.
- o_mbus_rdata  out  MEM_DQ_WIDTH*BURST_LENGTH  read beat.
- o_mbus_rdata_rq  out  1  o_mbus_rdata valid, one cycle per beat.
- o_mbus_rbusy  out  1  transaction in progress.
- o_mbus_rsel  out  1  request granted.
- o_axi_araddr  out  CTRL_ADDR_WIDTH  AXI read address.
- o_axi_arlen  out  8  constant BURST_BEATS-1.
- o_axi_arvalid  out  1  AR valid.
- i_axi_arready  in  1  AR ready.
- i_axi_rdata  in  MEM_DQ_WIDTH*BURST_LENGTH  R data.
- i_axi_rresp  in  2  R response.
- i_axi_rlast  in  1  R last.
- i_axi_rvalid  in  1  R valid.
- o_axi_rready  out  1  R ready.
- o_rd_err_cnt  out  8  saturating count of beats with rresp != 0.

Behaviour:
- Clock and reset: one clock, i_axi_aclk. Reset i_rst is synchronous and active-high.
- Reset values: all outputs 0 except o_axi_arlen, which is constant BURST_BEATS-1. State IDLE. Beat counter 0. A reset mid-burst abandons the burst, returns to IDLE and does not wait for outstanding beats.
- All outputs are registered.
- IDLE:
  - rsel=0, rbusy=0.
  - When i_mbus_rrq=1 and i_mbus_rready=1 on the same edge: latch i_mbus_raddr into o_axi_araddr, set rsel=1, rbusy=1, arvalid=1, go to ADDR.
  - rrq=1 with rready=0 is not granted.
- ADDR:
  - arvalid held at 1 and araddr held stable until i_axi_arready=1.
  - On that edge: arvalid=0, rready=1, go to DATA.
  - arready arriving in the same cycle arvalid first rises counts as a handshake.
- DATA:
  - o_axi_rready=1 continuously.
  - On each i_axi_rvalid=1 edge, the next cycle has o_mbus_rdata=i_axi_rdata and o_mbus_rdata_rq=1 (latency 1). Otherwise rdata_rq=0 and rdata holds its last value.
  - Beat counter increments per beat and wraps to 0 at burst end.
  - A beat with i_axi_rresp != 0 increments o_rd_err_cnt, which saturates at 255. The data is still forwarded.
  - A beat with rvalid=1 and rlast=1 terminates the burst: rready=0, go to DONE.
- DONE:
  - rbusy=0, rsel=0. The last beat's rdata_rq pulse falls in this same cycle.
  - i_mbus_rrq is ignored. Next state IDLE.
  - Minimum spacing between grants is therefore 1 idle cycle.
- rbusy falls exactly 1 cycle after the last beat handshake. The requester detects this falling edge to advance its address.
- rvalid outside DATA is ignored, with no rdata_rq and no count.
- Back-to-back requests:
  - A request held high through DONE is granted on the first IDLE edge.
  - A second burst's address comes from i_mbus_raddr at that edge.

Optional Feature:
- RD_LAST_CHECK_EN:
  - Defined: the burst terminates on the internal beat counter reaching BURST_BEATS, not on rlast.
  - Adds output o_last_err (1 bit, reset 0). It pulses for one cycle in DONE if rlast was absent on beat BURST_BEATS or asserted on an earlier beat.
  - An early rlast does not end the burst.
- Undefined: termination on rlast only. o_last_err does not exist.

Test Plan:
- Single burst: rrq=1, rready=1, raddr=0x000FD200, arready=1 immediately, 16 beats with rdata=beat index and rlast on beat 16 -> araddr=0x000FD200 and arlen=15; rsel/rbusy high from grant to the beat-16 edge; 16 rdata_rq pulses carrying 0..15, each 1 cycle after its rvalid; rbusy low the cycle after beat 16.
- Backpressure: rready=0 with rrq=1 for 10 cycles, then rready=1 -> no arvalid during the 10 cycles; grant on the first edge with rready=1.
- AR stall and gaps: arready low 5 cycles; rvalid toggled 1/0 -> araddr stable while arvalid is high; exactly 16 pulses with no extra or missing beats.
- Errors: rresp=2 on beats 3 and 7 of burst 1, then 300 error beats -> err_cnt=2 after burst 1; err_cnt saturates at 255.
- Reset: i_rst=1 for 1 cycle at beat 8, then a new request with raddr=0x80 -> all outputs 0 after reset; new burst at 0x80 completes normally.
- RD_LAST_CHECK_EN: rlast on beat 12 -> burst still takes 16 beats; o_last_err pulses once in DONE. Without the macro, the burst ends at beat 12.
